// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus the
// held-instruction channel toward the core datapath.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem request
// at a time and holds the fetched word until the core accepts it.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            misalign,
  output logic [31:0]     fetch_count,
  fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic            req_valid_r;
  logic [XLEN-1:0] req_addr_r;
  logic            instr_valid_r;
  logic [XLEN-1:0] instr_r;
  logic [XLEN-1:0] instr_pc_r;
  logic            misalign_r;
  logic [31:0]     fetch_count_r;

  logic            accept_s;
  logic [XLEN-1:0] next_pc_s;
  logic            misalign_s;

  assign accept_s = instr_valid_r & bus.instr_ready;

  // Next PC and misalignment flag, only consumed on an accept cycle
  always_comb begin
    next_pc_s  = pc_r + XLEN'(4);
    misalign_s = 1'b0;
    if (pc_src) begin
      next_pc_s  = {pc_target[XLEN-1:2], 2'b00};
      misalign_s = (pc_target[1:0] != 2'b00);
    end else begin
      next_pc_s  = pc_r + XLEN'(4);
      misalign_s = 1'b0;
    end
  end

  // Fetch FSM with all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      req_valid_r   <= 1'b0;
      req_addr_r    <= RESET_PC;
      instr_valid_r <= 1'b0;
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= RESET_PC;
      misalign_r    <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r     <= REQ;
          req_valid_r <= 1'b1;
          req_addr_r  <= pc_r;
        end
        REQ: begin
          if (req_valid_r && bus.imem_req_ready) begin
            req_valid_r <= 1'b0;
            state_r     <= WAIT;
          end else begin
            req_valid_r <= 1'b1;
            req_addr_r  <= pc_r;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            instr_r       <= bus.imem_rsp_data;
            instr_pc_r    <= pc_r;
            instr_valid_r <= 1'b1;
            state_r       <= HOLD;
          end else begin
            state_r <= WAIT;
          end
        end
        HOLD: begin
          if (accept_s) begin
            pc_r          <= next_pc_s;
            misalign_r    <= misalign_s;
            fetch_count_r <= fetch_count_r + 32'd1;
            instr_valid_r <= 1'b0;
            instr_r       <= NOP_INSTR;
            req_valid_r   <= 1'b1;
            req_addr_r    <= next_pc_s;
            state_r       <= REQ;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_r;
  assign bus.imem_req_addr  = req_addr_r;
  assign bus.instr_valid    = instr_valid_r;
  assign bus.instr          = instr_r;
  assign bus.instr_pc       = instr_pc_r;
  assign bus.instr_pc_plus4 = instr_pc_r + XLEN'(4);
  assign misalign           = misalign_r;
  assign fetch_count        = fetch_count_r;

endmodule
